unified_mem_port_arbiter: RTL and testbench
===========================================

// Module: unified_mem_port_arbiter
// PURPOSE
//  Shares one fixed-latency unified memory port between the IF stage (instruction
//  fetch, read-only) and the MEM stage (lw/sw). Sits between the pipeline and the
//  memory; its stall outputs feed the hazard logic that freezes PC, IF/ID and EX/MEM.
//  Data side has priority; a starvation counter bounds how long fetch can be starved.
// PARAMETERS
//  MEM_LATENCY   2   cycles from the mem_req cycle to the cycle mem_rdata is valid (>=1)
//  STARVE_LIMIT  2   consecutive data grants with if_req pending before fetch is forced
//  AW            32  address width
//  DW            32  data width
// PORTS
//  clk        in   1   clock; all state updates on rising edge
//  reset      in   1   synchronous, active-high reset
//  if_req     in   1   fetch request; held high until if_valid
//  if_addr    in   AW  fetch address; stable while if_req high
//  if_rdata   out  DW  fetched instruction; valid when if_valid
//  if_valid   out  1   one-cycle completion pulse for fetch
//  if_stall   out  1   if_req & ~if_valid (combinational)
//  d_req      in   1   data request; held high until d_valid
//  d_we       in   1   1 = store, 0 = load
//  d_addr     in   AW  data address
//  d_wdata    in   DW  store data
//  d_rdata    out  DW  load data; valid when d_valid on a load
//  d_valid    out  1   one-cycle completion pulse (load data or store ack)
//  d_stall    out  1   d_req & ~d_valid (combinational)
//  mem_req    out  1   one-cycle issue strobe to memory
//  mem_we     out  1   write enable; only meaningful while mem_req
//  mem_addr   out  AW  registered address; holds after issue
//  mem_wdata  out  DW  registered write data; holds after issue
//  mem_rdata  in   DW  memory read data, valid MEM_LATENCY cycles after mem_req
// BEHAVIOUR
//  - Reset: state IDLE; mem_req, mem_we, if_valid, d_valid = 0; if_rdata, d_rdata,
//    mem_addr, mem_wdata = 0; wait counter = 0; starve counter = 0.
//  - States IDLE -> WAIT -> RESP -> IDLE. Each state lasts >=1 cycle.
//  - IDLE: on an edge with d_req | if_req, select a grant, latch the selected requester's
//    addr/we/wdata into mem_*, set cnt = MEM_LATENCY, and go to WAIT. With no
//    request, stay in IDLE.
//  - Grant: d_req wins unless if_req & (starve == STARVE_LIMIT), in which case IF wins.
//    starve increments, saturating, on a data grant while if_req is high. It clears
//    on an IF grant, or on a data grant with if_req low.
//  - WAIT: mem_req = 1 only in the first WAIT cycle (cycle I). mem_we = latched we in
//    that cycle and 0 otherwise. cnt decrements each cycle. At the end of the cycle
//    with cnt == 0 (cycle I+MEM_LATENCY), register mem_rdata into if_rdata or d_rdata
//    per grant, then go to RESP. d_rdata is unchanged on a store.
//  - RESP: only the granted valid is high, for exactly one cycle. Requests are NOT
//    sampled in RESP. A requester that keeps req high after valid is treated as issuing
//    a new request, seen in the following IDLE. Next state is IDLE.
//  - Latency: request seen at the end of IDLE cycle T -> valid in cycle
//    T+MEM_LATENCY+2. Back-to-back throughput is one access per MEM_LATENCY+3 cycles.
//  - Only one access is outstanding at a time. A request dropped mid-WAIT still
//    completes and pulses valid (caller ignores it). No abort path.
//  - Simultaneous if_req & d_req in IDLE: the grant rule above applies. The loser's
//    stall stays high until its own valid.
//  - if_valid & d_valid are never both high. mem_req never asserts outside WAIT.
//  - Reset mid-WAIT/RESP: return to IDLE next cycle with all outputs at reset values.
//    The in-flight memory response is discarded and no valid is produced.
// TESTING
//  1 Fetch only, MEM_LATENCY=2: if_req, if_addr=0x10 with mem returning 0x00500093 ->
//    mem_req in cycle 1; if_valid and if_rdata=0x00500093 in cycle 4; if_stall low in 4.
//  2 Store then load: d_req, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF -> mem_we=1 with
//    mem_req, d_valid pulse. Then d_we=0 to the same addr -> d_rdata=0xDEADBEEF.
//  3 Conflict, STARVE_LIMIT=2: if_req and d_req both held continuously -> grant order
//    D,D,I,D,D,I. No simultaneous valids. mem_req pulses exactly once per grant.
//  4 Requester holds req through valid: a second access is issued only after RESP.
//    Valid spacing equals MEM_LATENCY+3 cycles.
//  5 Reset asserted in the cycle after mem_req: no valid is ever produced. mem_addr=0.
//    A new if_req after reset completes normally.
//  6 MEM_LATENCY=1 and MEM_LATENCY=4 regressions: valid arrives at T+3 and T+6 respectively.

Source files
------------

// File: rtl/unified_mem_port_arbiter.sv
// Unified memory port arbiter: one fixed-latency memory port shared between
// instruction fetch and the data stage. Data side wins by default; a
// starvation counter forces a fetch grant after STARVE_LIMIT consecutive
// data grants taken while fetch was waiting.
//
// state  | meaning
// S_IDLE | nothing in flight; sample requests, pick a grant, latch the access
// S_WAIT | access issued (mem_req in first cycle); latency down-counter runs
// S_RESP | one-cycle valid pulse for the granted side; requests not sampled
module unified_mem_port_arbiter #(
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 2,
    parameter int AW           = 32,
    parameter int DW           = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    output logic          if_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_valid,
    output logic          d_stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    localparam int CW = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);
    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LAT_LOAD   = CW'(MEM_LATENCY);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [SW-1:0] starve;
    logic          grant_d;
    logic          we_q;
    logic          any_req;
    logic          pick_if;
    logic          lat_done;

    assign any_req  = if_req | d_req;
    assign pick_if  = if_req & (~d_req | (starve == STARVE_MAX));
    assign lat_done = (cnt == '0);
    assign if_stall = if_req & ~if_valid;
    assign d_stall  = d_req & ~d_valid;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: each state lasts at least one cycle, RESP always returns to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (any_req) state_nxt = S_WAIT;
            S_WAIT:  if (lat_done) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Issue strobe, latency countdown, response capture and starvation tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_valid  <= 1'b0;
            d_valid   <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            cnt       <= '0;
            starve    <= '0;
            grant_d   <= 1'b0;
            we_q      <= 1'b0;
        end else begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        grant_d <= ~pick_if;
                        we_q    <= ~pick_if & d_we;
                        mem_req <= 1'b1;
                        mem_we  <= ~pick_if & d_we;
                        cnt     <= LAT_LOAD;
                        if (pick_if) begin
                            mem_addr <= if_addr;
                            starve   <= '0;
                        end else begin
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            if (!if_req) begin
                                starve <= '0;
                            end else if (starve != STARVE_MAX) begin
                                starve <= starve + 1'b1;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    if (lat_done) begin
                        if (grant_d) begin
                            d_valid <= 1'b1;
                            if (!we_q) d_rdata <= mem_rdata;
                        end else begin
                            if_valid <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem_port_arbiter.sv
// Bench for unified_mem_port_arbiter: instance 0 (latency 2) is checked every
// cycle against a transaction-level model; instances 1 and 2 (latency 1 and 4)
// get directed latency checks. A memory device model answers mem_req with the
// read word only in the due cycle and random junk otherwise.
module tb_unified_mem_port_arbiter;
    localparam int L0 = 2;
    localparam int SLIM = 2;

    logic        clk;
    logic        rst       [3];
    logic        if_req    [3];
    logic [31:0] if_addr   [3];
    logic [31:0] if_rdata  [3];
    logic        if_valid  [3];
    logic        if_stall  [3];
    logic        d_req     [3];
    logic        d_we      [3];
    logic [31:0] d_addr    [3];
    logic [31:0] d_wdata   [3];
    logic [31:0] d_rdata   [3];
    logic        d_valid   [3];
    logic        d_stall   [3];
    logic        mem_req   [3];
    logic        mem_we    [3];
    logic [31:0] mem_addr  [3];
    logic [31:0] mem_wdata [3];
    logic [31:0] mem_rdata [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        unified_mem_port_arbiter #(
            .MEM_LATENCY (g == 0 ? 2 : (g == 1 ? 1 : 4)),
            .STARVE_LIMIT(SLIM),
            .AW          (32),
            .DW          (32)
        ) dut (
            .clk      (clk),
            .reset    (rst[g]),
            .if_req   (if_req[g]),
            .if_addr  (if_addr[g]),
            .if_rdata (if_rdata[g]),
            .if_valid (if_valid[g]),
            .if_stall (if_stall[g]),
            .d_req    (d_req[g]),
            .d_we     (d_we[g]),
            .d_addr   (d_addr[g]),
            .d_wdata  (d_wdata[g]),
            .d_rdata  (d_rdata[g]),
            .d_valid  (d_valid[g]),
            .d_stall  (d_stall[g]),
            .mem_req  (mem_req[g]),
            .mem_we   (mem_we[g]),
            .mem_addr (mem_addr[g]),
            .mem_wdata(mem_wdata[g]),
            .mem_rdata(mem_rdata[g])
        );
    end

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit started = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    function automatic void chk32(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void chk1(string name, logic act, logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b required %b (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Backing store contents: device copy and model copy are kept separately
    logic [31:0] dev    [logic [31:0]];
    logic [31:0] shadow [logic [31:0]];

    function automatic logic [31:0] init_word(logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    function automatic logic [31:0] dev_rd(logic [31:0] a);
        return dev.exists(a) ? dev[a] : init_word(a);
    endfunction

    function automatic logic [31:0] shadow_rd(logic [31:0] a);
        return shadow.exists(a) ? shadow[a] : init_word(a);
    endfunction

    function automatic int lat_of(int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
    endfunction

    // Memory device: read word presented only in the cycle MEM_LATENCY after issue
    int          due      [3];
    logic [31:0] due_addr [3];
    initial begin
        for (int i = 0; i < 3; i++) begin
            due[i] = -1;
            due_addr[i] = '0;
            mem_rdata[i] = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (due[i] == cyc) mem_rdata[i] = dev_rd(due_addr[i]);
                else mem_rdata[i] = $urandom;
                if (mem_req[i] === 1'b1) begin
                    if (mem_we[i] === 1'b1) begin
                        dev[mem_addr[i]] = mem_wdata[i];
                    end else begin
                        due[i] = cyc + lat_of(i);
                        due_addr[i] = mem_addr[i];
                    end
                end
            end
        end
    end

    // Transaction model for instance 0: one access at a time, issue the cycle
    // after the request is seen, valid L0+1 cycles after issue.
    bit          m_busy = 0;
    bit          m_gd = 0;
    bit          m_gwe = 0;
    int          m_ic = -1;
    int          m_vc = -1;
    int          m_starve = 0;
    logic [31:0] m_data = '0;
    logic [31:0] e_maddr = '0;
    logic [31:0] e_mwdata = '0;
    logic [31:0] e_ifrd = '0;
    logic [31:0] e_drd = '0;
    bit          e_mreq, e_mwe, e_ifv, e_dv, m_pick_if;
    logic [31:0] m_addr;

    initial forever begin
        @(negedge clk);
        if (started) begin
            e_mreq = m_busy && (cyc == m_ic);
            e_mwe  = e_mreq && m_gwe;
            e_ifv  = m_busy && (cyc == m_vc) && !m_gd;
            e_dv   = m_busy && (cyc == m_vc) && m_gd;
            if (e_ifv) e_ifrd = m_data;
            if (e_dv && !m_gwe) e_drd = m_data;
            chk1("mem_req", mem_req[0], e_mreq);
            chk1("mem_we", mem_we[0], e_mwe);
            chk32("mem_addr", mem_addr[0], e_maddr);
            chk32("mem_wdata", mem_wdata[0], e_mwdata);
            chk1("if_valid", if_valid[0], e_ifv);
            chk1("d_valid", d_valid[0], e_dv);
            chk32("if_rdata", if_rdata[0], e_ifrd);
            chk32("d_rdata", d_rdata[0], e_drd);
            chk1("if_stall", if_stall[0], if_req[0] & ~e_ifv);
            chk1("d_stall", d_stall[0], d_req[0] & ~e_dv);
            if (rst[0]) begin
                m_busy = 0;
                m_starve = 0;
                e_maddr = '0;
                e_mwdata = '0;
                e_ifrd = '0;
                e_drd = '0;
            end else if (!m_busy) begin
                if (if_req[0] || d_req[0]) begin
                    m_pick_if = if_req[0] && (!d_req[0] || m_starve == SLIM);
                    if (m_pick_if) m_starve = 0;
                    else if (if_req[0]) m_starve = (m_starve < SLIM) ? m_starve + 1 : SLIM;
                    else m_starve = 0;
                    m_gd   = !m_pick_if;
                    m_gwe  = m_gd && d_we[0];
                    m_addr = m_gd ? d_addr[0] : if_addr[0];
                    e_maddr = m_addr;
                    if (m_gd) e_mwdata = d_wdata[0];
                    if (m_gwe) shadow[m_addr] = d_wdata[0];
                    else m_data = shadow_rd(m_addr);
                    m_ic = cyc + 1;
                    m_vc = cyc + L0 + 2;
                    m_busy = 1;
                end
            end else if (cyc == m_vc) begin
                m_busy = 0;
            end
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Watch instance i from the cycle its request was raised; offsets are in cycles
    task automatic run_access(input int i, input bit is_d, input int max_cyc,
                              output int t_mreq, output int t_val, output bit we_at_req);
        t_mreq = -1;
        t_val = -1;
        we_at_req = 0;
        for (int n = 0; n < max_cyc; n++) begin
            @(negedge clk);
            if (mem_req[i] === 1'b1 && t_mreq < 0) begin
                t_mreq = n;
                we_at_req = mem_we[i];
            end
            if ((is_d ? d_valid[i] : if_valid[i]) === 1'b1) begin
                t_val = n;
                break;
            end
        end
    endtask

    int          t_mreq, t_val, t1, t2, nval, nreq, nboth, v0, v1;
    bit          we_at;
    logic [5:0]  order;
    logic [31:0] rd1, rd2;

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1;
            if_req[i] = 1'b0;
            if_addr[i] = '0;
            d_req[i] = 1'b0;
            d_we[i] = 1'b0;
            d_addr[i] = '0;
            d_wdata[i] = '0;
        end
        dev[32'h10] = 32'h00500093;
        shadow[32'h10] = 32'h00500093;
        dev[32'h80] = 32'h12345678;

        next_cyc();
        started = 1;
        next_cyc();
        @(negedge clk);
        chk1("rst_mem_req", mem_req[0], 1'b0);
        chk32("rst_mem_addr", mem_addr[0], 32'h0);
        chk32("rst_if_rdata", if_rdata[0], 32'h0);
        chk32("rst_d_rdata", d_rdata[0], 32'h0);
        chk1("rst_valids", if_valid[0] | d_valid[0], 1'b0);
        next_cyc();
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;

        // Fetch only
        next_cyc();
        if_req[0] = 1'b1;
        if_addr[0] = 32'h10;
        run_access(0, 0, 12, t_mreq, t_val, we_at);
        chk32("fetch_mreq_cycle", 32'(t_mreq), 32'd1);
        chk32("fetch_valid_cycle", 32'(t_val), 32'd4);
        chk32("fetch_rdata", if_rdata[0], 32'h00500093);
        chk1("fetch_stall_at_valid", if_stall[0], 1'b0);
        next_cyc();
        if_req[0] = 1'b0;

        // Store then load
        next_cyc();
        d_req[0] = 1'b1;
        d_we[0] = 1'b1;
        d_addr[0] = 32'h40;
        d_wdata[0] = 32'hDEADBEEF;
        run_access(0, 1, 12, t_mreq, t_val, we_at);
        chk1("store_mem_we", we_at, 1'b1);
        chk32("store_valid_cycle", 32'(t_val), 32'd4);
        next_cyc();
        d_req[0] = 1'b0;
        next_cyc();
        d_req[0] = 1'b1;
        d_we[0] = 1'b0;
        run_access(0, 1, 12, t_mreq, t_val, we_at);
        chk1("load_mem_we", we_at, 1'b0);
        chk32("load_rdata", d_rdata[0], 32'hDEADBEEF);
        next_cyc();
        d_req[0] = 1'b0;

        // Conflict: both held continuously
        next_cyc();
        if_req[0] = 1'b1;
        if_addr[0] = 32'h14;
        d_req[0] = 1'b1;
        d_we[0] = 1'b0;
        d_addr[0] = 32'h44;
        order = '0;
        nval = 0;
        nreq = 0;
        nboth = 0;
        for (int n = 0; n < 80 && nval < 6; n++) begin
            @(negedge clk);
            if (mem_req[0] === 1'b1) nreq++;
            if (if_valid[0] === 1'b1 && d_valid[0] === 1'b1) nboth++;
            if (if_valid[0] === 1'b1 || d_valid[0] === 1'b1) begin
                order = {order[4:0], d_valid[0]};
                nval++;
            end
        end
        chk32("conflict_valid_count", 32'(nval), 32'd6);
        chk32("conflict_grant_order", {26'd0, order}, 32'b110110);
        chk32("conflict_mem_req_pulses", 32'(nreq), 32'd6);
        chk32("conflict_both_valid", 32'(nboth), 32'd0);
        next_cyc();
        if_req[0] = 1'b0;
        d_req[0] = 1'b0;

        // Requester holds req through valid
        next_cyc();
        d_req[0] = 1'b1;
        d_we[0] = 1'b0;
        d_addr[0] = 32'h40;
        v0 = -1;
        v1 = -1;
        for (int n = 0; n < 40 && v1 < 0; n++) begin
            @(negedge clk);
            if (d_valid[0] === 1'b1) begin
                if (v0 < 0) v0 = n;
                else v1 = n;
            end
        end
        chk32("hold_first_valid", 32'(v0), 32'd4);
        chk32("hold_valid_spacing", 32'(v1 - v0), 32'd5);
        next_cyc();
        d_req[0] = 1'b0;

        // Reset in the cycle after mem_req
        next_cyc();
        if_req[0] = 1'b1;
        if_addr[0] = 32'h10;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (mem_req[0] === 1'b1) break;
        end
        next_cyc();
        rst[0] = 1'b1;
        if_req[0] = 1'b0;
        next_cyc();
        rst[0] = 1'b0;
        nval = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (if_valid[0] === 1'b1 || d_valid[0] === 1'b1) nval++;
        end
        chk32("reset_no_valid", 32'(nval), 32'd0);
        chk32("reset_mem_addr", mem_addr[0], 32'h0);
        next_cyc();
        if_req[0] = 1'b1;
        run_access(0, 0, 12, t_mreq, t_val, we_at);
        chk32("post_reset_valid_cycle", 32'(t_val), 32'd4);
        chk32("post_reset_rdata", if_rdata[0], 32'h00500093);
        next_cyc();
        if_req[0] = 1'b0;

        // Latency 1 and 4 instances
        next_cyc();
        if_req[1] = 1'b1;
        if_req[2] = 1'b1;
        if_addr[1] = 32'h80;
        if_addr[2] = 32'h80;
        t1 = -1;
        t2 = -1;
        rd1 = '0;
        rd2 = '0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (if_valid[1] === 1'b1 && t1 < 0) begin
                t1 = n;
                rd1 = if_rdata[1];
            end
            if (if_valid[2] === 1'b1 && t2 < 0) begin
                t2 = n;
                rd2 = if_rdata[2];
            end
            if (t1 == n) if_req[1] = 1'b0;
        end
        if_req[2] = 1'b0;
        chk32("lat1_valid_cycle", 32'(t1), 32'd3);
        chk32("lat4_valid_cycle", 32'(t2), 32'd6);
        chk32("lat1_rdata", rd1, 32'h12345678);
        chk32("lat4_rdata", rd2, 32'h12345678);

        // Randomised traffic on instance 0
        for (int n = 0; n < 3000; n++) begin
            next_cyc();
            rst[0] = ($urandom_range(0, 499) == 0);
            if (if_req[0]) begin
                if (if_valid[0]) begin
                    if ($urandom_range(0, 1) == 1) if_addr[0] = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                    else if_req[0] = 1'b0;
                end else if ($urandom_range(0, 99) == 0) begin
                    if_req[0] = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                if_req[0] = 1'b1;
                if_addr[0] = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            end
            if (d_req[0]) begin
                if (d_valid[0]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        d_we[0] = 1'($urandom_range(0, 1));
                        d_addr[0] = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                        d_wdata[0] = $urandom;
                    end else begin
                        d_req[0] = 1'b0;
                    end
                end else if ($urandom_range(0, 99) == 0) begin
                    d_req[0] = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                d_req[0] = 1'b1;
                d_we[0] = 1'($urandom_range(0, 1));
                d_addr[0] = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                d_wdata[0] = $urandom;
            end
        end
        next_cyc();
        rst[0] = 1'b0;
        if_req[0] = 1'b0;
        d_req[0] = 1'b0;
        repeat (10) next_cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
